// File: rtl/pipe_sequencer.sv
// pipe_sequencer
// ---------------
// Pipeline sequencer for the MIPS core. Owns the fetch PC and a per-stage
// bookkeeping slot (valid, dst, wr, load, halt) for stages 1..STAGES-1. From
// these it generates the load enables for the datapath pipeline registers.
// Stage map: 0 = IF, 1 = ID, 2 = EX, 3..STAGES-2 = MEM, STAGES-1 = WB.
//
// Each cycle resolves to one action, highest priority first:
//   halted      : everything frozen, stage_en = 0
//   mem_busy    : whole pipeline frozen, PC included
//   redirect    : PC <= redirect_pc, ID and EX squashed, older stages advance
//   halt-pending: halt token in EX or older; PC holds, bubble into ID
//   hazard      : PC and ID hold, bubble into EX, older stages advance
//   normal      : PC += 4, ID takes the id_* fields, all stages shift
//
// Configuration macro: PIPE_FWD_EN
//   defined   : datapath forwards ALU results, so only load-use against
//               slots 2..STAGES-3 interlocks.
//   undefined : full interlock against every valid writer in slots
//               2..STAGES-1.
//
// Ports
//   clk, rst_b          clock; asynchronous active-low reset
//   mem_busy            memory stage not ready, freezes the pipeline
//   redirect_valid/pc   taken branch / jump / jr resolved in EX
//   id_rs, id_rt        ID source registers, qualified by id_rs/rt_used
//   id_dst, id_wr       ID destination register and write flag
//   id_load, id_halt    ID instruction is a load / a halt
//   pc_out              current fetch address (registered)
//   stage_en            bit s: register feeding stage s loads (bit 0 = PC)
//   stage_valid         bit s: stage s holds a live instruction
//   stall_hazard        register interlock taken this cycle
//   halted              sticky, set when a halt leaves WB

module pipe_sequencer #(
  parameter int unsigned   STAGES   = 5,
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              mem_busy,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [4:0]        id_dst,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_halt,
  output logic [AW-1:0]     pc_out,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              stall_hazard,
  output logic              halted
);

  // Bookkeeping carried alongside each in-flight instruction.
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       wr;
    logic       load;
    logic       halt;
  } slot_t;

  // Action chosen for the current cycle.
  typedef enum logic [2:0] {
    ModeHalted,
    ModeFreeze,
    ModeRedirect,
    ModeHaltPend,
    ModeHazard,
    ModeNormal
  } mode_e;

  localparam int unsigned WB = STAGES - 1;

  logic [AW-1:0] pc_q, pc_d;
  logic          halted_q, halted_d;
  slot_t         slot_q [1:STAGES-1];
  slot_t         slot_d [1:STAGES-1];

  slot_t id_slot;
  logic  hazard;
  logic  halt_pend;
  mode_e mode;

  assign id_slot = '{valid: 1'b1, dst: id_dst, wr: id_wr, load: id_load, halt: id_halt};

  // Register interlock: a used, non-zero source of the ID instruction matches
  // the destination of an older in-flight writer that cannot be forwarded.
  always_comb begin
    logic rs_hit;
    logic rt_hit;
    logic cand;
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int unsigned s = 2; s < STAGES; s++) begin
      cand = slot_q[s].valid && slot_q[s].wr && (slot_q[s].dst != 5'd0);
`ifdef PIPE_FWD_EN
      // ALU results forward; only a load still in EX/early MEM must wait.
      cand = cand && slot_q[s].load && (s <= STAGES - 3);
`endif
      if (cand && id_rs_used && (id_rs == slot_q[s].dst)) rs_hit = 1'b1;
      if (cand && id_rt_used && (id_rt == slot_q[s].dst)) rt_hit = 1'b1;
    end
    hazard = slot_q[1].valid && (rs_hit || rt_hit);
  end

  // A halt in EX or beyond stops fetch so nothing younger can follow it.
  always_comb begin
    halt_pend = 1'b0;
    for (int unsigned s = 2; s < STAGES; s++) begin
      if (slot_q[s].valid && slot_q[s].halt) halt_pend = 1'b1;
    end
  end

  always_comb begin
    if (halted_q) begin
      mode = ModeHalted;
    end else if (mem_busy) begin
      mode = ModeFreeze;
    end else if (redirect_valid) begin
      mode = ModeRedirect;
    end else if (halt_pend) begin
      mode = ModeHaltPend;
    end else if (hazard) begin
      mode = ModeHazard;
    end else begin
      mode = ModeNormal;
    end
  end

  // Next-state and stage enables.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    slot_d   = slot_q;
    stage_en = '0;

    unique case (mode)
      ModeHalted: begin
      end
      ModeFreeze: begin
      end
      ModeRedirect: begin
        // No delay slot: both the wrong-path fetch in ID and the one now
        // entering EX are squashed; the redirecting instruction moves on.
        pc_d      = redirect_pc;
        slot_d[1] = '0;
        slot_d[2] = '0;
        for (int unsigned s = 3; s < STAGES; s++) slot_d[s] = slot_q[s-1];
        stage_en  = '1;
      end
      ModeHaltPend: begin
        slot_d[1] = '0;
        for (int unsigned s = 2; s < STAGES; s++) slot_d[s] = slot_q[s-1];
        stage_en    = '1;
        stage_en[0] = 1'b0;
      end
      ModeHazard: begin
        slot_d[2] = '0;
        for (int unsigned s = 3; s < STAGES; s++) slot_d[s] = slot_q[s-1];
        stage_en      = '1;
        stage_en[1:0] = 2'b00;
      end
      ModeNormal: begin
        pc_d      = pc_q + AW'(4);
        slot_d[1] = id_slot;
        for (int unsigned s = 2; s < STAGES; s++) slot_d[s] = slot_q[s-1];
        stage_en  = '1;
      end
      default: begin
      end
    endcase

    // The halt retires on the edge at which it leaves an unfrozen WB.
    if (!halted_q && !mem_busy && slot_q[WB].valid && slot_q[WB].halt) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      for (int unsigned s = 1; s < STAGES; s++) slot_q[s] <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    stage_valid[0] = !halted_q;
    for (int unsigned s = 1; s < STAGES; s++) stage_valid[s] = slot_q[s].valid;
  end

  assign stall_hazard = (mode == ModeHazard);
  assign pc_out       = pc_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
module tb_pipe_sequencer;

  localparam int          S   = 5;
  localparam logic [31:0] RPC = 32'h0;

  localparam int MHALT = 0;
  localparam int MBUSY = 1;
  localparam int MREDIR = 2;
  localparam int MHP = 3;
  localparam int MHAZ = 4;
  localparam int MNORM = 5;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          mem_busy = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [4:0]    id_rs = '0, id_rt = '0, id_dst = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic          id_wr = 1'b0, id_load = 1'b0, id_halt = 1'b0;
  logic [31:0]   pc_out;
  logic [S-1:0]  stage_en, stage_valid;
  logic          stall_hazard, halted;

  pipe_sequencer #(.STAGES(S), .AW(32), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .mem_busy      (mem_busy),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .id_dst        (id_dst),
    .id_wr         (id_wr),
    .id_load       (id_load),
    .id_halt       (id_halt),
    .pc_out        (pc_out),
    .stage_en      (stage_en),
    .stage_valid   (stage_valid),
    .stall_hazard  (stall_hazard),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Reference model: instruction records by stage, index 0 unused.
  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       ht;
  } ins_t;

  ins_t        pipe [S];
  logic [31:0] m_pc;
  logic        m_halted;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0]  obs_pc;
  logic [S-1:0] obs_valid, obs_en;
  logic         obs_stall, obs_halted;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // True when register r is still being produced by an instruction whose
  // result the datapath cannot hand to ID yet.
  function automatic logic pending_write(input logic [4:0] r);
    int   hi;
    logic need_ld;
`ifdef PIPE_FWD_EN
    hi = S - 3;
    need_ld = 1'b1;
`else
    hi = S - 1;
    need_ld = 1'b0;
`endif
    if (r == 5'd0) return 1'b0;
    for (int s = 2; s <= hi; s++) begin
      if (pipe[s].v && pipe[s].wr && pipe[s].dst == r && (!need_ld || pipe[s].ld)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_mode();
    logic hp;
    logic hz;
    hp = 1'b0;
    for (int s = 2; s < S; s++) if (pipe[s].v && pipe[s].ht) hp = 1'b1;
    hz = pipe[1].v && ((id_rs_used && pending_write(id_rs)) ||
                       (id_rt_used && pending_write(id_rt)));
    if (m_halted) return MHALT;
    if (mem_busy) return MBUSY;
    if (redirect_valid) return MREDIR;
    if (hp) return MHP;
    if (hz) return MHAZ;
    return MNORM;
  endfunction

  // Enables cover every stage from the lowest one that loads upward.
  function automatic logic [S-1:0] m_en(input int mode);
    logic [S-1:0] ones;
    ones = '1;
    case (mode)
      MNORM, MREDIR: return ones;
      MHP:           return ones << 1;
      MHAZ:          return ones << 2;
      default:       return '0;
    endcase
  endfunction

  function automatic logic [S-1:0] m_valid();
    logic [S-1:0] v;
    v[0] = !m_halted;
    for (int s = 1; s < S; s++) v[s] = pipe[s].v;
    return v;
  endfunction

  // Advance the model by one edge: inject at stage k, everything older shifts.
  task automatic m_step(input int mode);
    int   k;
    ins_t inj;
    if (!m_halted && !mem_busy && pipe[S-1].v && pipe[S-1].ht) m_halted = 1'b1;
    k = 0;
    inj = '0;
    case (mode)
      MNORM: begin k = 1; inj = '{v: 1'b1, dst: id_dst, wr: id_wr, ld: id_load, ht: id_halt}; end
      MHP:   k = 1;
      MHAZ:  k = 2;
      MREDIR: k = 2;
      default: k = 0;
    endcase
    if (k != 0) begin
      for (int s = S - 1; s > k; s--) pipe[s] = pipe[s-1];
      pipe[k] = inj;
    end
    if (mode == MREDIR) begin
      pipe[1] = '0;
      m_pc = redirect_pc;
    end
    if (mode == MNORM) m_pc = m_pc + 32'd4;
  endtask

  task automatic cycle();
    int mode;
    #1;
    mode = m_mode();
    obs_pc = pc_out;
    obs_valid = stage_valid;
    obs_en = stage_en;
    obs_stall = stall_hazard;
    obs_halted = halted;
    chk("pc_out", pc_out, m_pc);
    chk("stage_en", stage_en, m_en(mode));
    chk("stage_valid", stage_valid, m_valid());
    chk("stall_hazard", stall_hazard, mode == MHAZ);
    chk("halted", halted, m_halted);
    @(posedge clk);
    m_step(mode);
    @(negedge clk);
  endtask

  task automatic reset_async();
    rst_b = 1'b0;
    #1;
    m_pc = RPC;
    m_halted = 1'b0;
    for (int s = 0; s < S; s++) pipe[s] = '0;
    chk("rst_pc", pc_out, RPC);
    chk("rst_valid", stage_valid, 1);
    chk("rst_halted", halted, 0);
    #2;
    rst_b = 1'b1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                        input logic rtu, input logic [4:0] dst, input logic wr,
                        input logic ld, input logic ht);
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_dst = dst; id_wr = wr; id_load = ld; id_halt = ht;
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int stalls;
    int bubbles;
    logic [31:0]  pc_hold;
    logic [S-1:0] v_hold;
    logic [S-1:0] fill [6];
    fill[0] = 5'h01; fill[1] = 5'h03; fill[2] = 5'h07;
    fill[3] = 5'h0F; fill[4] = 5'h1F; fill[5] = 5'h1F;

    set_nop();
    @(negedge clk);
    reset_async();

    // Fill: sequential fetch addresses, valid bits ripple in.
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("fill_pc", obs_pc, 32'(4 * i));
      chk("fill_valid", obs_valid, fill[i]);
    end

    // addi $2 ; add $3,$2,$2
    set_id(0, 0, 0, 0, 2, 1, 0, 0);
    cycle();
    set_id(2, 1, 2, 1, 3, 1, 0, 0);
    stalls = 0; bubbles = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      stalls += int'(obs_stall);
      bubbles += int'(!obs_valid[2]);
    end
`ifdef PIPE_FWD_EN
    chk("alu_dep_stalls", stalls, 0);
    chk("alu_dep_bubbles", bubbles, 0);
`else
    chk("alu_dep_stalls", stalls, 3);
    chk("alu_dep_bubbles", bubbles, 3);
`endif
    set_nop();
    for (int i = 0; i < 5; i++) cycle();

    // lw $4 ; sub $5,$4,$0
    set_id(0, 0, 0, 0, 4, 1, 1, 0);
    cycle();
    set_id(4, 1, 0, 1, 5, 1, 0, 0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      stalls += int'(obs_stall);
    end
`ifdef PIPE_FWD_EN
    chk("load_use_stalls", stalls, 1);
`else
    chk("load_use_stalls", stalls, 3);
`endif
    set_nop();
    for (int i = 0; i < 5; i++) cycle();

    // Same pattern through $0 never interlocks.
    set_id(0, 0, 0, 0, 0, 1, 1, 0);
    cycle();
    set_id(0, 1, 0, 1, 5, 1, 0, 0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      stalls += int'(obs_stall);
    end
    chk("zero_reg_stalls", stalls, 0);
    set_nop();
    for (int i = 0; i < 5; i++) cycle();

    // Redirect while a load-use hazard is active.
    set_id(0, 0, 0, 0, 6, 1, 1, 0);
    cycle();
    set_id(6, 1, 0, 0, 7, 1, 0, 0);
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("redir_pc", obs_pc, 32'h100);
    chk("redir_id_valid", obs_valid[1], 0);
    chk("redir_ex_valid", obs_valid[2], 0);
    chk("redir_stall", obs_stall, 0);
    set_nop();
    for (int i = 0; i < 5; i++) cycle();

    // mem_busy for 4 cycles with a redirect pending.
    mem_busy = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    pc_hold = m_pc;
    v_hold = m_valid();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("busy_pc", obs_pc, pc_hold);
      chk("busy_valid", obs_valid, v_hold);
      chk("busy_en", obs_en, 0);
    end
    mem_busy = 1'b0;
    cycle();
    set_nop();
    cycle();
    chk("busy_redir_pc", obs_pc, 32'h200);
    for (int i = 0; i < 5; i++) cycle();

    // Halt token.
    set_id(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    set_nop();
    cycle();
    pc_hold = m_pc;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("halt_pc_frozen", obs_pc, pc_hold);
      chk("halt_flag", obs_halted, i == 3);
    end
    cycle();
    reset_async();

    // PC wraps modulo 2^32.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    set_nop();
    cycle();
    chk("wrap_top", obs_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_zero", obs_pc, 32'h0);

    // Randomized traffic against the model, with async resets sprinkled in.
    for (int i = 0; i < 800; i++) begin
      mem_busy = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      set_id(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
        reset_async();
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
